// File: rtl/vec_writeback.sv
// Vector result writeback: snapshots a packed result buffer on a flag rising edge
// and writes it word-by-word into a 32-word scratch memory with a host preload port.

module vec_wb_word #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)       r_q <= '0;
        else if (i_we) r_q <= i_wdata;
    end

    assign o_q = r_q;
endmodule

module vec_writeback #(
    parameter int NUM_SIZE        = 16,
    parameter int VEC_BUFFER_LEN  = 8,
    parameter int WORDS_IN_MEMORY = 32,
    localparam int AW = $clog2(WORDS_IN_MEMORY),
    localparam int LW = $clog2(VEC_BUFFER_LEN)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SIZE*VEC_BUFFER_LEN-1:0]  flat_vec_buffer,
    input  logic                                copy_vec_buffer_flag,
    input  logic [AW-1:0]                       dest_buffer,
    input  logic [LW-1:0]                       length_buffer,
    input  logic                                host_we,
    input  logic [AW-1:0]                       host_addr,
    input  logic [NUM_SIZE-1:0]                 host_wdata,
    output logic [NUM_SIZE*WORDS_IN_MEMORY-1:0] flat_memory,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);
    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                                    r_state;
    logic                                      r_flag_q;
    logic [LW-1:0]                             r_cnt;
    logic [LW-1:0]                             r_len_snap;
    logic [AW-1:0]                             r_dest_snap;
    logic [VEC_BUFFER_LEN-1:0][NUM_SIZE-1:0]   r_vec_snap;
    logic                                      r_busy;
    logic                                      r_done;
    logic                                      r_err;

    logic                                      w_start;
    logic [AW-1:0]                             w_wr_addr;
    logic [NUM_SIZE-1:0]                       w_wr_data;
    logic [WORDS_IN_MEMORY-1:0][NUM_SIZE-1:0]  w_mem;

    assign w_start   = copy_vec_buffer_flag & ~r_flag_q;
    // Address arithmetic is AW bits wide so the destination wraps around memory.
    assign w_wr_addr = r_dest_snap + AW'(r_cnt);
    assign w_wr_data = r_vec_snap[r_cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flag_q    <= 1'b0;
            r_cnt       <= '0;
            r_len_snap  <= '0;
            r_dest_snap <= '0;
            r_vec_snap  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_flag_q <= copy_vec_buffer_flag;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_vec_snap  <= flat_vec_buffer;
                        r_dest_snap <= dest_buffer;
                        r_len_snap  <= length_buffer;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Host writes and new requests collide with the transfer: drop them and flag.
                    if (host_we || w_start) r_err <= 1'b1;
                    if (r_cnt == r_len_snap) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WORDS_IN_MEMORY; i++) begin : g_word
        logic w_wb_we;
        logic w_host_we;

        assign w_wb_we   = (r_state == S_WRITE) && (w_wr_addr == AW'(i));
        assign w_host_we = (r_state == S_IDLE) && host_we && (host_addr == AW'(i));

        vec_wb_word #(.W(NUM_SIZE)) u_word (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_wb_we | w_host_we),
            .i_wdata (w_wb_we ? w_wr_data : host_wdata),
            .o_q     (w_mem[i])
        );
    end

    assign flat_memory = w_mem;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
endmodule
